// File: rtl/usart_tx.sv
// usart_tx: 8N1 UART transmitter, one byte per send/sent handshake; USART_TX_LED_EN enables tx_led.
// Latency: start bit on the cycle after send is accepted; busy 10*DIV cycles; send while busy is dropped.
module usart_tx #(
  parameter int fsm_clk_freq = 16000000,
  parameter int baud_rate    = 115200
) (
  input  logic       clk,
  input  logic       reset,
  output logic       tx_led,
  input  logic [7:0] data,
  input  logic       send,
  output logic       sent,
  output logic       tx
);

  localparam int DIV   = fsm_clk_freq / baud_rate;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [CNT_W-1:0] baud_cnt_d;
  logic [2:0]       bit_idx_q;
  logic [2:0]       bit_idx_d;
  logic [7:0]       data_q;
  logic             tx_q;
  logic             sent_q;
  logic             bit_end;
`ifdef USART_TX_LED_EN
  logic             led_q;
`endif

  assign bit_end    = (baud_cnt_q == CNT_MAX);
  assign baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
  assign bit_idx_d  = bit_idx_q + 3'd1;

  // Outputs are updated together with the state so every one is a flop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      data_q     <= '0;
      tx_q       <= 1'b1;
      sent_q     <= 1'b1;
`ifdef USART_TX_LED_EN
      led_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          baud_cnt_q <= '0;
          bit_idx_q  <= '0;
          if (send) begin
            data_q  <= data;
            state_q <= START;
            tx_q    <= 1'b0;
            sent_q  <= 1'b0;
`ifdef USART_TX_LED_EN
            led_q   <= 1'b1;
`endif
          end
        end
        START: begin
          baud_cnt_q <= baud_cnt_d;
          if (bit_end) begin
            state_q <= DATA;
            tx_q    <= data_q[0];
          end
        end
        DATA: begin
          baud_cnt_q <= baud_cnt_d;
          if (bit_end) begin
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_d;
              tx_q      <= data_q[bit_idx_d];
            end
          end
        end
        STOP: begin
          baud_cnt_q <= baud_cnt_d;
          if (bit_end) begin
            state_q <= IDLE;
            sent_q  <= 1'b1;
`ifdef USART_TX_LED_EN
            led_q   <= 1'b0;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign sent = sent_q;
`ifdef USART_TX_LED_EN
  assign tx_led = led_q;
`else
  assign tx_led = 1'b0;
`endif

endmodule

// File: tb/tb_usart_tx.sv
// Scoreboard bench for usart_tx at DIV=10: bytes queued at send, decoded off tx mid-bit and compared.
module tb_usart_tx;

  localparam int DIV = 10;
`ifdef USART_TX_LED_EN
  localparam logic LED_ON = 1'b1;
`else
  localparam logic LED_ON = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       send  = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       tx_led;
  logic       sent;
  logic       tx;

  int n_checks = 0;
  int n_pass   = 0;
  int pcnt     = 0;
  int frames   = 0;
  int aborts   = 0;
  logic [7:0] sb[$];

  logic [7:0] mon_byte;
  logic       mon_st;
  logic       mon_sp;
  bit         mon_ab;

  usart_tx #(
    .fsm_clk_freq(1000000),
    .baud_rate   (100000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .tx_led(tx_led),
    .data  (data),
    .send  (send),
    .sent  (sent),
    .tx    (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcnt <= pcnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Monitor wait that bails out as soon as reset is seen low.
  task automatic mon_wait(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        mon_ab = 1'b1;
        return;
      end
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        mon_ab = 1'b0;
        mon_wait(DIV/2 - 1);
        mon_st = tx;
        for (int k = 0; k < 8; k++) begin
          if (!mon_ab) begin
            mon_wait(DIV);
            mon_byte[k] = tx;
          end
        end
        if (!mon_ab) begin
          mon_wait(DIV);
          mon_sp = tx;
        end
        if (mon_ab) begin
          aborts++;
          if (sb.size() != 0) void'(sb.pop_front());
        end else begin
          frames++;
          chk("start_bit", {31'd0, mon_st}, 32'd0);
          chk("stop_bit", {31'd0, mon_sp}, 32'd1);
          chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
          if (sb.size() != 0) chk("frame_byte", {24'd0, mon_byte}, {24'd0, sb.pop_front()});
        end
      end
    end
  end

  // Called on a negedge; returns on the negedge after the accepting edge (cycle 1).
  task automatic send_byte(input logic [7:0] b, input bit expect_frame, output int t0);
    data = b;
    send = 1'b1;
    if (expect_frame) sb.push_back(b);
    @(negedge clk);
    send = 1'b0;
    t0 = pcnt;
  endtask

  task automatic wait_idle(input int t0, output int dt);
    int guard;
    guard = 0;
    while (sent !== 1'b1 && guard < 20*DIV) begin
      @(negedge clk);
      guard++;
    end
    dt = pcnt - t0;
    chk("idle_reached", {31'd0, sent}, 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int t0, t1, dt, n;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_sent", {31'd0, sent}, 32'd1);
    chk("rst_led", {31'd0, tx_led}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_tx", {31'd0, tx}, 32'd1);
    chk("rel_sent", {31'd0, sent}, 32'd1);

    // Reset and send in the same cycle: nothing latched.
    reset = 1'b0; send = 1'b1; data = 8'h12;
    @(negedge clk);
    reset = 1'b1; send = 1'b0;
    n = 0;
    repeat (2*DIV) begin
      @(negedge clk);
      if (sent !== 1'b1 || tx !== 1'b1) n++;
    end
    chk("rst_wins", n, 0);

    // Single byte
    send_byte(8'h41, 1'b1, t0);
    chk("c1_tx", {31'd0, tx}, 32'd0);
    chk("c1_sent", {31'd0, sent}, 32'd0);
    chk("c1_led", {31'd0, tx_led}, {31'd0, LED_ON});
    wait_idle(t0, dt);
    chk("busy_len_41", dt, 10*DIV);
    chk("idle_led", {31'd0, tx_led}, 32'd0);

    // Busy ignore: 0xAA at cycle 30 must be dropped
    @(negedge clk);
    send_byte(8'h55, 1'b1, t0);
    repeat (29) @(negedge clk);
    send_byte(8'hAA, 1'b0, t1);
    wait_idle(t0, dt);
    chk("busy_len_55", dt, 10*DIV);
    n = 0;
    repeat (3*DIV) begin
      @(negedge clk);
      if (sent !== 1'b1) n++;
    end
    chk("stay_idle", n, 0);

    // Data change after acceptance
    send_byte(8'hFF, 1'b1, t0);
    @(negedge clk);
    data = 8'h00;
    wait_idle(t0, dt);
    chk("busy_len_ff", dt, 10*DIV);

    // Back-to-back on the first idle cycle
    @(negedge clk);
    send_byte(8'h0F, 1'b1, t0);
    wait_idle(t0, dt);
    send_byte(8'hF0, 1'b1, t1);
    chk("b2b_gap", t1 - t0, 10*DIV + 1);
    chk("b2b_start", {31'd0, tx}, 32'd0);
    wait_idle(t1, dt);
    chk("busy_len_f0", dt, 10*DIV);

    // Reset mid-frame at cycle 45 (a 0 data bit is on the line then)
    @(negedge clk);
    send_byte(8'h96, 1'b1, t0);
    repeat (44) @(negedge clk);
    chk("pre_abort_tx", {31'd0, tx}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_tx", {31'd0, tx}, 32'd1);
    chk("abort_sent", {31'd0, sent}, 32'd1);
    chk("abort_led", {31'd0, tx_led}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_cnt", aborts, 1);
    send_byte(8'h33, 1'b1, t0);
    wait_idle(t0, dt);
    chk("busy_len_33", dt, 10*DIV);

    repeat (DIV) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("frames", frames, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/usart_tx.md
# usart_tx

Transmit-only asynchronous serial (UART) port. Accepts one byte at a time from a controller via a `send`/`sent` handshake and shifts it out on `tx` as an 8N1 frame at a fixed baud rate derived from the system clock. It sits at the output of the MD5 search generator and streams the recovered cleartext to a host.

## Interface
Parameters:
- `fsm_clk_freq`, 16000000: system clock frequency in Hz.
- `baud_rate`, 115200: serial bit rate in bit/s.
- Derived: `DIV = fsm_clk_freq / baud_rate`, using integer division truncated toward zero; this gives 138 at the defaults. `DIV >= 2` is required.

Ports:
- `clk`, input, 1: single system clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `tx_led`, output, 1: activity indicator; high while a frame is in flight.
- `data`, input, 8: byte to transmit; sampled only when a send is accepted.
- `send`, input, 1: request strobe.
- `sent`, output, 1: ready/done flag; high when idle and able to accept.
- `tx`, output, 1: serial line; idles high.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- State machine:
  - IDLE: `tx`=1, `sent`=1. If `send`=1, latch `data`, then go to START.
  - START: `tx`=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: `tx`=latched bit[index] for DIV cycles. The index increments after each bit; after index 7, go to STOP.
  - STOP: `tx`=1 for DIV cycles, then go to IDLE.
- `sent` is low in START, DATA and STOP.
- `tx_led` is high in START, DATA and STOP (see Configuration).
- `send` is ignored outside IDLE. A pulse while busy is dropped, not queued.
- The latched byte is held for the whole frame. Changes on `data` after acceptance have no effect.
- Internal counters:
  - Baud counter: width clog2(DIV), counting 0..DIV-1, wrapping to 0 at each bit boundary.
  - Bit index: 3 bits.
- Reset (`reset`=0 at a rising edge) gives: state IDLE, `tx`=1, `sent`=1, `tx_led`=0, counters 0. Reset mid-frame aborts the frame immediately; no stop bit is sent.

## Timing
- Call the edge where `send`=1 is sampled in IDLE cycle 0. All outputs are registered.
- From cycle 1: `tx`=0, `sent`=0, `tx_led`=1.
- Start bit occupies cycles 1..DIV.
- Data bit k occupies cycles 1+(k+1)·DIV .. (k+2)·DIV.
- Stop bit occupies cycles 1+9·DIV .. 10·DIV.
- At cycle 10·DIV+1: `sent`=1 and `tx_led`=0.
- Total busy time is exactly 10·DIV cycles.
- Back-to-back: if `send`=1 on the first cycle `sent` is high, the next start bit begins one cycle later. The minimum gap between frames is 1 idle cycle.
- A one-cycle `send` pulse is sufficient. If `send` is held high, one frame is sent per 10·DIV+1 cycles.
- Simultaneous `reset`=0 and `send`=1: reset wins and nothing is latched.

## Configuration
- Macro `USART_TX_LED_EN`.
- Defined: `tx_led` mirrors the busy state as described above.
- Undefined: `tx_led` is tied to 0, and the frame logic is unchanged.

## Test plan
All scenarios use `fsm_clk_freq`=1000000 and `baud_rate`=100000, so DIV=10.
- Reset: hold `reset`=0 for 3 cycles, then release -> `tx`=1, `sent`=1, `tx_led`=0.
- Single byte: pulse `send` with `data`=0x41 -> `tx` reads 0,1,0,0,0,0,0,1,0,1 at 10-cycle spacing, sampled mid-bit. `sent` is low for exactly 100 cycles.
- Busy ignore: send 0x55, then pulse `send` with 0xAA at cycle 30 -> only 0x55 is framed. `sent` rises at cycle 101 and stays high.
- Data change: send 0xFF, then drive `data`=0x00 at cycle 2 -> all 8 data bits are 1.
- Back-to-back: pulse `send` with 0x0F, then pulse `send` with 0xF0 on the first cycle `sent`=1 -> second start bit begins one cycle later and decodes as 0xF0.
- Reset mid-frame: assert reset at cycle 45 -> `tx`=1 and `sent`=1 on the next cycle. A following send of 0x33 frames correctly.
